// File: rtl/cmp_slice_accum_if.sv
// Slice-stream interface between the 2-bit comparator side (master) and the
// sequential magnitude accumulator (slave).
interface cmp_slice_accum_if;
    logic start;
    logic in_valid;
    logic in_l;
    logic in_e;
    logic in_g;
    logic in_ready;
    logic busy;
    logic done;
    logic res_l;
    logic res_e;
    logic res_g;
    logic err;

    modport master (
        output start, in_valid, in_l, in_e, in_g,
        input  in_ready, busy, done, res_l, res_e, res_g, err
    );

    modport slave (
        input  start, in_valid, in_l, in_e, in_g,
        output in_ready, busy, done, res_l, res_e, res_g, err
    );
endinterface

// File: rtl/cmp_slice_accum.sv
// Sequential wide-operand magnitude accumulator. Consumes one less/equal/greater
// triple per accepted beat, most significant slice first; the first non-equal
// slice decides the result. After NSLICE beats the result is presented on
// registered outputs with a one-cycle done pulse and held until the next start.
module cmp_slice_accum #(
    parameter int NSLICE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_slice_accum_if.slave  bus
);
    localparam int CW = $clog2(NSLICE + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef enum logic [1:0] {ACC_EQ, ACC_LT, ACC_GT}   acc_t;

    state_t         r_state;
    acc_t           r_acc;
    logic           r_decided;
    logic           r_err;
    logic [CW-1:0]  r_cnt;
    logic           r_in_ready;
    logic           r_busy;
    logic           r_done;
    logic [2:0]     r_res;

    logic [2:0]     w_flags;
    logic           w_onehot;
    logic           w_last;
    acc_t           w_acc_next;
    logic           w_decided_next;
    logic           w_err_next;

    // Result encoding (l,e,g); an error during the comparison invalidates it.
    function automatic logic [2:0] encode(input acc_t a, input logic e);
        logic [2:0] r;
        r = 3'b010;
        if (e) begin
            r = 3'b000;
        end else if (a == ACC_LT) begin
            r = 3'b100;
        end else if (a == ACC_GT) begin
            r = 3'b001;
        end
        return r;
    endfunction

    assign w_flags  = {bus.in_l, bus.in_e, bus.in_g};
    assign w_onehot = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
    assign w_last   = (r_cnt == CW'(NSLICE - 1));

    // Outcome of the current beat: first non-equal slice decides, bad triples flag err.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_acc_next     = r_acc;
        w_decided_next = r_decided;
        w_err_next     = r_err;
        if (!w_onehot) begin
            w_err_next = 1'b1;
        end else if (!r_decided) begin
            if (bus.in_l) begin
                w_acc_next     = ACC_LT;
                w_decided_next = 1'b1;
            end else if (bus.in_g) begin
                w_acc_next     = ACC_GT;
                w_decided_next = 1'b1;
            end
        end
    end

    // Control FSM with registered status outputs and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state is updated with non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            r_state    <= ST_IDLE;
            r_acc      <= ACC_EQ;
            r_decided  <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_res      <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_RUN;
                        r_acc      <= ACC_EQ;
                        r_decided  <= 1'b0;
                        r_err      <= 1'b0;
                        r_cnt      <= '0;
                        r_res      <= 3'b000;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.in_valid) begin
                        r_acc     <= w_acc_next;
                        r_decided <= w_decided_next;
                        r_err     <= w_err_next;
                        r_cnt     <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_res      <= encode(w_acc_next, w_err_next);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.res_l    = r_res[2];
    assign bus.res_e    = r_res[1];
    assign bus.res_g    = r_res[0];
    assign bus.err      = r_err;
endmodule

// File: tb/tb_cmp_slice_accum.sv
// Scoreboard bench for cmp_slice_accum (NSLICE=4): directed slice sequences push
// hand-computed results; a monitor compares whenever done is presented.
module tb_cmp_slice_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    typedef struct packed {
        logic [2:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    cmp_slice_accum_if bus ();

    cmp_slice_accum #(.NSLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks there see settled outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] f);
        bus.in_valid = 1'b1;
        {bus.in_l, bus.in_e, bus.in_g} = f;
        tick();
        bus.in_valid = 1'b0;
        {bus.in_l, bus.in_e, bus.in_g} = 3'b000;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    function automatic logic [2:0] res_now();
        return {bus.res_l, bus.res_e, bus.res_g};
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got res=%b err=%b with empty queue", res_now(), bus.err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_res", 32'(res_now()), 32'(e.res));
                check("sb_err", 32'(bus.err), 32'(e.err));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        {bus.in_l, bus.in_e, bus.in_g} = 3'b000;
        tick();
        tick();
        check("rst_ready", 32'(bus.in_ready), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_done",  32'(bus.done), 0);
        check("rst_res",   32'(res_now()), 0);
        check("rst_err",   32'(bus.err), 0);
        rst_n = 1'b1;
        tick();

        // Equal operands, no bubbles.
        sb.push_back('{res: 3'b010, err: 1'b0});
        do_start();
        check("eq_ready", 32'(bus.in_ready), 1);
        check("eq_busy",  32'(bus.busy), 1);
        beat(3'b010); beat(3'b010); beat(3'b010);
        check("eq_not_done_yet", 32'(bus.done), 0);
        beat(3'b010);
        check("eq_done_t4", 32'(bus.done), 1);
        check("eq_ready_done", 32'(bus.in_ready), 0);
        tick();
        check("eq_busy_drop", 32'(bus.busy), 0);
        check("eq_done_drop", 32'(bus.done), 0);

        // MSB slice decides; later slices do not override.
        sb.push_back('{res: 3'b100, err: 1'b0});
        do_start();
        beat(3'b100); beat(3'b001); beat(3'b001); beat(3'b010);
        tick();

        // Late decision with bubbles: done 7 edges after start.
        sb.push_back('{res: 3'b001, err: 1'b0});
        do_start();
        beat(3'b010);
        tick(); tick(); tick();
        check("bub_no_count", 32'(bus.done), 0);
        beat(3'b010); beat(3'b001);
        check("bub_not_done", 32'(bus.done), 0);
        beat(3'b100);
        check("bub_done_t7", 32'(bus.done), 1);
        tick();

        // Error: non-one-hot triple invalidates the result; next start clears err.
        sb.push_back('{res: 3'b000, err: 1'b1});
        do_start();
        beat(3'b010); beat(3'b110); beat(3'b001); beat(3'b010);
        tick();
        check("err_hold_idle", 32'(bus.err), 1);
        sb.push_back('{res: 3'b010, err: 1'b0});
        do_start();
        check("err_cleared", 32'(bus.err), 0);
        check("res_cleared", 32'(res_now()), 0);
        beat(3'b010); beat(3'b010); beat(3'b010); beat(3'b010);
        tick();
        check("res_hold_010", 32'(res_now()), 32'h2);

        // Reset mid-operation discards the partial comparison.
        do_start();
        beat(3'b100); beat(3'b100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy",  32'(bus.busy), 0);
        check("mid_rst_ready", 32'(bus.in_ready), 0);
        check("mid_rst_done",  32'(bus.done), 0);
        check("mid_rst_res",   32'(res_now()), 0);
        check("mid_rst_err",   32'(bus.err), 0);
        sb.push_back('{res: 3'b001, err: 1'b0});
        do_start();
        beat(3'b001); beat(3'b001); beat(3'b001); beat(3'b001);
        tick();

        // Start pulsed during RUN is ignored.
        sb.push_back('{res: 3'b100, err: 1'b0});
        do_start();
        beat(3'b010);
        bus.start = 1'b1;
        beat(3'b100);
        bus.start = 1'b0;
        beat(3'b001);
        check("run_start_ignored", 32'(bus.done), 0);
        beat(3'b010);
        check("run_start_done", 32'(bus.done), 1);
        tick();

        // Start with in_valid in IDLE: that slice is not accepted.
        sb.push_back('{res: 3'b001, err: 1'b0});
        bus.start = 1'b1;
        beat(3'b100);
        bus.start = 1'b0;
        beat(3'b001); beat(3'b010); beat(3'b010);
        check("idle_beat_not_counted", 32'(bus.done), 0);
        beat(3'b010);
        check("idle_beat_done", 32'(bus.done), 1);
        tick();

        // Result held stable through idle cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("res_stable", 32'(res_now()), 32'h1);
        end

        tick();
        check("sb_empty", 32'(sb.size()), 0);
        check("done_count", 32'(n_done), 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
